// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// FSM state encoding plus size / read-write field values.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

endpackage

// File: rtl/dmem_access_ctrl_rr_arbiter_2.sv
// Two-way round-robin arbiter: on a tie the port that was not granted last wins.
// Ports: req[1:0], en, last_grant (index of last winner) -> one-hot grant[1:0].
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates two requesters onto the data memory: one latched request,
// one ACCESS cycle, one RESP cycle with ack/err/rdata to the winner.
// Ports: clk, reset (sync, high); pN_req/rw/size/addr/wdata in;
// pN_ack/err/rdata out; mem_a/di/size/rw/e out; mem_do in.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_rw,
  input  logic              p0_size,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_rw,
  input  logic              p1_size,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_di,
  output logic              mem_size,
  output logic              mem_rw,
  output logic              mem_e,
  input  logic [DATA_W-1:0] mem_do
);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                port_q, port_d;
  logic                rw_q, rw_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [DATA_W-1:0]   mem_di_q, mem_di_d;
  logic                mem_size_q, mem_size_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [1:0]          grant;
  logic                sel;
  logic                sel_rw;
  logic                sel_size;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                misaligned;
  logic                resp;

  rr_arbiter_2 u_arb (
    .req        ({p1_req, p0_req}),
    .en         (state_q == IDLE),
    .last_grant (last_q),
    .grant      (grant)
  );

  always_comb begin
    sel       = grant[1];
    sel_rw    = sel ? p1_rw    : p0_rw;
    sel_size  = sel ? p1_size  : p0_size;
    sel_addr  = sel ? p1_addr  : p0_addr;
    sel_wdata = sel ? p1_wdata : p0_wdata;
    misaligned = ALIGN_CHECK
              && (sel_size == SIZE_WORD)
              && (sel_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    rw_d       = rw_q;
    err_d      = err_q;
    mem_a_d    = mem_a_q;
    mem_di_d   = mem_di_q;
    mem_size_d = mem_size_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          last_d  = sel;
          port_d  = sel;
          rw_d    = sel_rw;
          err_d   = misaligned;
          rdata_d = '0;
          if (misaligned) begin
            state_d = RESP;
          end else begin
            // Memory-facing address/data only move on a real access.
            mem_a_d    = sel_addr;
            mem_di_d   = sel_wdata;
            mem_size_d = sel_size;
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (rw_q == RW_WRITE)
          rdata_d = '0;
        else if (mem_size_q == SIZE_WORD)
          rdata_d = mem_do;
        else
          rdata_d = {{(DATA_W-8){1'b0}}, mem_do[7:0]};
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      port_q     <= 1'b0;
      rw_q       <= RW_READ;
      err_q      <= 1'b0;
      mem_a_q    <= '0;
      mem_di_q   <= '0;
      mem_size_q <= SIZE_BYTE;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      port_q     <= port_d;
      rw_q       <= rw_d;
      err_q      <= err_d;
      mem_a_q    <= mem_a_d;
      mem_di_q   <= mem_di_d;
      mem_size_q <= mem_size_d;
      rdata_q    <= rdata_d;
    end
  end

  // Enable is gated by reset so an aborted ACCESS never writes.
  assign mem_e    = (state_q == ACCESS) && !reset;
  assign mem_rw   = mem_e && (rw_q == RW_WRITE);
  assign mem_a    = mem_a_q;
  assign mem_di   = mem_di_q;
  assign mem_size = mem_size_q;

  assign resp     = (state_q == RESP);
  assign p0_ack   = resp && !port_q;
  assign p1_ack   = resp && port_q;
  assign p0_err   = p0_ack && err_q;
  assign p1_err   = p1_ack && err_q;
  assign p0_rdata = p0_ack ? rdata_q : '0;
  assign p1_rdata = p1_ack ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 256-byte memory model
// and a per-cycle transaction scoreboard.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_rw, p0_size;
  logic [7:0]  p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_rw, p1_size;
  logic [7:0]  p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack, p1_err;
  logic [31:0] p1_rdata;
  logic [7:0]  mem_a;
  logic [31:0] mem_di;
  logic        mem_size, mem_rw, mem_e;
  logic [31:0] mem_do;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_size(p0_size),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_size(p1_size),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_a(mem_a), .mem_di(mem_di), .mem_size(mem_size),
    .mem_rw(mem_rw), .mem_e(mem_e), .mem_do(mem_do)
  );

  // Physical memory driven by the DUT.
  logic [7:0] ram [256];

  always_comb begin
    if (mem_size)
      mem_do = {ram[mem_a], ram[mem_a + 8'd1],
                ram[mem_a + 8'd2], ram[mem_a + 8'd3]};
    else
      mem_do = {24'h0, ram[mem_a]};
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (mem_e && mem_rw) begin
        if (mem_size) begin
          ram[mem_a]        <= mem_di[31:24];
          ram[mem_a + 8'd1] <= mem_di[23:16];
          ram[mem_a + 8'd2] <= mem_di[15:8];
          ram[mem_a + 8'd3] <= mem_di[7:0];
        end else begin
          ram[mem_a] <= mem_di[7:0];
        end
      end
    end
  end

  // Reference model: memory contents as seen by completed transactions.
  logic [7:0] model_mem [256];
  bit         model_last;

  function automatic logic [31:0] mword(logic [7:0] a);
    return {model_mem[a], model_mem[a + 8'd1],
            model_mem[a + 8'd2], model_mem[a + 8'd3]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Outstanding transaction expected by the compare process.
  bit          pend_valid = 0;
  int          pend_cnt   = 0;
  bit          pend_port, pend_err, pend_rw, pend_size;
  logic [7:0]  pend_addr;
  logic [31:0] pend_wdata, pend_rdata;

  always begin
    bit fin;
    bit exp_e;
    @(posedge clk);
    #1;
    if (pend_valid) pend_cnt--;
    fin   = pend_valid && (pend_cnt == 0);
    exp_e = pend_valid && !pend_err && (pend_cnt == 1) && !reset;
    chk("p0_ack", 32'(p0_ack), 32'(fin && !pend_port));
    chk("p1_ack", 32'(p1_ack), 32'(fin && pend_port));
    chk("p0_err", 32'(p0_err), 32'(fin && !pend_port && pend_err));
    chk("p1_err", 32'(p1_err), 32'(fin && pend_port && pend_err));
    chk("p0_rdata", p0_rdata, (fin && !pend_port) ? pend_rdata : 32'h0);
    chk("p1_rdata", p1_rdata, (fin && pend_port) ? pend_rdata : 32'h0);
    chk("mem_e", 32'(mem_e), 32'(exp_e));
    chk("mem_rw", 32'(mem_rw), 32'(exp_e && pend_rw));
    if (exp_e) begin
      chk("mem_a", 32'(mem_a), 32'(pend_addr));
      chk("mem_size", 32'(mem_size), 32'(pend_size));
      chk("mem_di", mem_di, pend_wdata);
    end
    if (fin) pend_valid = 0;
  end

  task automatic set_pend(bit port, bit rw, bit size,
                          logic [7:0] addr, logic [31:0] wdata);
    pend_port  = port;
    pend_rw    = rw;
    pend_size  = size;
    pend_addr  = addr;
    pend_wdata = wdata;
    pend_err   = size && (addr[1:0] != 2'b00);
    if (pend_err || rw) pend_rdata = 32'h0;
    else if (size)      pend_rdata = mword(addr);
    else                pend_rdata = {24'h0, model_mem[addr]};
    pend_cnt   = pend_err ? 1 : 2;
    pend_valid = 1;
  endtask

  task automatic drive(bit port, bit req, bit rw, bit size,
                       logic [7:0] addr, logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_rw = rw; p1_size = size;
      p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_rw = rw; p0_size = size;
      p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic model_write(bit size, logic [7:0] a, logic [31:0] d);
    if (size) begin
      model_mem[a]        = d[31:24];
      model_mem[a + 8'd1] = d[23:16];
      model_mem[a + 8'd2] = d[15:8];
      model_mem[a + 8'd3] = d[7:0];
    end else begin
      model_mem[a] = d[7:0];
    end
  endtask

  task automatic issue(input bit port, input bit rw, input bit size,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output bit er);
    bit got;
    bit mis;
    int lat;
    @(negedge clk);
    set_pend(port, rw, size, addr, wdata);
    mis = pend_err;
    drive(port, 1'b1, rw, size, addr, wdata);
    got = 0;
    lat = 0;
    rd  = 32'hx;
    er  = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (port ? p1_ack : p0_ack) begin
        got = 1;
        lat = i + 1;
        rd  = port ? p1_rdata : p0_rdata;
        er  = port ? p1_err : p0_err;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", lat, mis ? 32'd1 : 32'd2);
    drive(port, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    if (!mis && rw) model_write(size, addr, wdata);
    model_last = port;
  endtask

  task automatic tie(output bit winner);
    bit w;
    bit got;
    @(negedge clk);
    w = !model_last;
    if (w) set_pend(1'b1, 1'b0, 1'b1, 8'h40, 32'h1111_1111);
    else   set_pend(1'b0, 1'b0, 1'b1, 8'h10, 32'h0000_0000);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 32'h0000_0000);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 32'h1111_1111);
    got = 0;
    winner = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        got = 1;
        winner = p1_ack;
      end
    end
    chk("tie_ack_seen", 32'(got), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    model_last = w;
  endtask

  logic [31:0] rd;
  bit          er;
  bit          win;
  bit [3:0]    win_exp;

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'h5A;
    model_last = 1'b1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);

    // Reset held three cycles; compare process checks outputs each cycle.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_a", 32'(mem_a), 32'h0);
    chk("rst_mem_di", mem_di, 32'h0);
    chk("rst_mem_size", 32'(mem_size), 32'h0);

    // Word write then read back on port 0.
    issue(1'b0, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, rd, er);
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_rdata", rd, 32'h0);
    issue(1'b0, 1'b0, 1'b1, 8'h10, 32'h0, rd, er);
    chk("rd_word", rd, 32'hDEAD_BEEF);
    chk("rd_err", 32'(er), 32'd0);

    // Byte write from port 1 merges into the big-endian word.
    issue(1'b1, 1'b1, 1'b0, 8'h13, 32'h0000_00A5, rd, er);
    issue(1'b0, 1'b0, 1'b1, 8'h10, 32'h0, rd, er);
    chk("rd_merged", rd, 32'hDEAD_BEA5);
    issue(1'b1, 1'b0, 1'b0, 8'h13, 32'h0, rd, er);
    chk("rd_byte", rd, 32'h0000_00A5);

    // Round-robin ties: p0, p1, p0, p1.
    win_exp = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tie(win);
      chk("tie_winner", 32'(win), 32'(win_exp[k]));
    end

    // Misaligned word write is rejected and leaves memory alone.
    issue(1'b0, 1'b1, 1'b1, 8'h22, 32'hCAFE_F00D, rd, er);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'h0);
    for (int a = 8'h22; a <= 8'h25; a++) begin
      issue(1'b1, 1'b0, 1'b0, 8'(a), 32'h0, rd, er);
      chk("mis_untouched", rd, {24'h0, model_mem[a]});
    end
    chk("mis_lit", 32'(ram[8'h22]), 32'h78);

    // Reset during ACCESS of a write aborts it.
    @(negedge clk);
    set_pend(1'b0, 1'b1, 1'b1, 8'h30, 32'h1122_3344);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h30, 32'h1122_3344);
    @(negedge clk);
    chk("abort_in_access", 32'(mem_e), 32'd1);
    reset = 1'b1;
    pend_valid = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_last = 1'b1;
    chk("abort_no_ack", 32'(p0_ack), 32'd0);
    tie(win);
    chk("post_rst_tie", 32'(win), 32'd0);
    issue(1'b0, 1'b0, 1'b1, 8'h30, 32'h0, rd, er);
    chk("abort_mem", rd, 32'h6A6B_6869);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
